// File: rtl/master_controller_if.sv
// Phase broadcast bus between the master_controller sequencer and the layer datapath.
// The controller drives the phase, counters and status; the datapath drives start.
interface master_controller_if #(
    parameter int max      = 5,
    parameter int layer_no = 4
);
    localparam int LW = (layer_no > 1) ? $clog2(layer_no) : 1;
    localparam int CW = (max > 1) ? $clog2(max) : 1;

    logic          start;
    logic [2:0]    control;
    logic [LW-1:0] layer_idx;
    logic [CW-1:0] mac_cnt;
    logic          busy;
    logic          done;

    modport master (input start, output control, layer_idx, mac_cnt, busy, done);
    modport slave  (output start, input control, layer_idx, mac_cnt, busy, done);
endinterface

// File: rtl/master_controller.sv
// Phase sequencer for the neural network: LOAD, MAC x max, ACT, NEXT per layer.
// Define MASTER_CONTROLLER_AUTO_RESTART_EN to restart directly from DONE while start stays high.
module master_controller #(
    parameter int max      = 5,
    parameter int layer_no = 4
) (
    input logic               clk,
    input logic               rst,
    master_controller_if.master bus
);
    localparam int LW = (layer_no > 1) ? $clog2(layer_no) : 1;
    localparam int CW = (max > 1) ? $clog2(max) : 1;

    // State encoding equals the broadcast phase code, so control is the state register itself.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MAC  = 3'd2,
        ACT  = 3'd3,
        NEXT = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [LW-1:0] layer_q, layer_next;
    logic [CW-1:0] mac_q, mac_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            layer_q <= '0;
            mac_q   <= '0;
        end else begin
            state   <= state_next;
            layer_q <= layer_next;
            mac_q   <= mac_next;
        end
    end

    // mac_next defaults to zero so the MAC index is cleared in every non-MAC state.
    always_comb begin
        state_next = state;
        layer_next = layer_q;
        mac_next   = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                    layer_next = '0;
                end
            end
            LOAD: state_next = MAC;
            MAC: begin
                if (mac_q == CW'(max - 1)) begin
                    state_next = ACT;
                end else begin
                    mac_next = mac_q + 1'b1;
                end
            end
            ACT: begin
                if (layer_q == LW'(layer_no - 1)) begin
                    state_next = DONE;
                end else begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                state_next = LOAD;
                layer_next = layer_q + 1'b1;
            end
            DONE: begin
                if (!bus.start) begin
                    state_next = IDLE;
                end else begin
`ifdef MASTER_CONTROLLER_AUTO_RESTART_EN
                    state_next = LOAD;
                    layer_next = '0;
`else
                    state_next = DONE;
`endif
                end
            end
            default: begin
                state_next = IDLE;
                layer_next = '0;
            end
        endcase
    end

    assign bus.control   = state;
    assign bus.layer_idx = layer_q;
    assign bus.mac_cnt   = mac_q;
    assign bus.busy      = (state != IDLE) && (state != DONE);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_master_controller.sv
// Self-checking bench for master_controller: a (5,4) instance and a (1,1) instance,
// compared against a cycle-position model of the phase schedule.
module tb_master_controller;
    localparam int MX   = 5;
    localparam int NL   = 4;
    localparam int LAST = NL * (MX + 3) - 1;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    master_controller_if #(.max(MX), .layer_no(NL)) bus_a ();
    master_controller_if #(.max(1),  .layer_no(1))  bus_b ();

    master_controller #(.max(MX), .layer_no(NL)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    master_controller #(.max(1),  .layer_no(1))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs t cycles after the start edge, from the per-layer cycle budget.
    function automatic void model_at(input int mx, input int nl, input int t,
                                     output int ctl, output int lay, output int mc);
        int per;
        int r;
        per = mx + 3;
        mc  = 0;
        if (t >= nl * per - 1) begin
            ctl = 5;
            lay = nl - 1;
        end else begin
            lay = t / per;
            r   = t % per;
            if (r == 0) ctl = 1;
            else if (r <= mx) begin
                ctl = 2;
                mc  = r - 1;
            end else if (r == mx + 1) ctl = 3;
            else ctl = 4;
        end
    endfunction

    function automatic logic [7:0] pack_exp(input int ctl, input int lay, input int mc);
        logic busy_e;
        logic done_e;
        busy_e = (ctl >= 1) && (ctl <= 4);
        done_e = (ctl == 5);
        return {3'(ctl), 2'(lay), 1'b0, busy_e, done_e} | {5'b0, 3'b0} | 8'(0);
    endfunction

    task automatic test_reset();
        int k;
        rst = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        #12;
        n_tests++;
        if ({bus_a.control, bus_a.layer_idx, bus_a.mac_cnt, bus_a.busy, bus_a.done} !== 10'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_a: got %h expected 0",
                     {bus_a.control, bus_a.layer_idx, bus_a.mac_cnt, bus_a.busy, bus_a.done});
        end
        n_tests++;
        if ({bus_b.control, bus_b.busy, bus_b.done} !== 5'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_b: got %h expected 0", {bus_b.control, bus_b.busy, bus_b.done});
        end
        @(negedge clk);
        rst = 1'b0;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        k = $urandom_range(2, 25);
        repeat (k) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({bus_a.control, bus_a.busy, bus_a.done} !== 5'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_midrun after %0d cycles: got %h expected 0", k,
                     {bus_a.control, bus_a.busy, bus_a.done});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_run();
        int ctl, lay, mc, idle;
        for (int run = 0; run < 3; run++) begin
            idle = $urandom_range(1, 3);
            for (int i = 0; i < idle; i++) begin
                @(negedge clk);
                n_tests++;
                if (bus_a.control !== 3'd0 || bus_a.busy !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL idle run%0d: control %0d busy %0d expected 0 0",
                             run, bus_a.control, bus_a.busy);
                end
            end
            bus_a.start = 1'b1;
            for (int t = 0; t <= LAST; t++) begin
                @(negedge clk);
                model_at(MX, NL, t, ctl, lay, mc);
                n_tests++;
                if ({bus_a.control, bus_a.layer_idx, bus_a.mac_cnt, bus_a.busy, bus_a.done} !==
                    {3'(ctl), 2'(lay), 3'(mc), ctl >= 1 && ctl <= 4, ctl == 5}) begin
                    n_fail++;
                    $display("[TB] FAIL run%0d t=%0d: got ctl %0d lay %0d mac %0d busy %0d done %0d expected ctl %0d lay %0d mac %0d",
                             run, t, bus_a.control, bus_a.layer_idx, bus_a.mac_cnt, bus_a.busy,
                             bus_a.done, ctl, lay, mc);
                end
                bus_a.start = (t == LAST) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n_tests++;
            if (bus_a.control !== 3'd0 || bus_a.done !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL after_done run%0d: control %0d done %0d expected 0 0",
                         run, bus_a.control, bus_a.done);
            end
        end
    endtask

    task automatic test_done_hold();
        int ctl, lay, mc, k;
        bus_a.start = 1'b1;
        for (int t = 0; t <= LAST; t++) begin
            @(negedge clk);
            model_at(MX, NL, t, ctl, lay, mc);
            n_tests++;
            if (bus_a.control !== 3'(ctl) || bus_a.layer_idx !== 2'(lay)) begin
                n_fail++;
                $display("[TB] FAIL hold_run t=%0d: got ctl %0d lay %0d expected ctl %0d lay %0d",
                         t, bus_a.control, bus_a.layer_idx, ctl, lay);
            end
        end
        k = $urandom_range(3, 6);
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
`ifdef MASTER_CONTROLLER_AUTO_RESTART_EN
            model_at(MX, NL, i - 1, ctl, lay, mc);
`else
            ctl = 5;
            lay = NL - 1;
`endif
            n_tests++;
            if (bus_a.control !== 3'(ctl) || bus_a.layer_idx !== 2'(lay)) begin
                n_fail++;
                $display("[TB] FAIL done_hold i=%0d: got ctl %0d lay %0d expected ctl %0d lay %0d",
                         i, bus_a.control, bus_a.layer_idx, ctl, lay);
            end
        end
`ifdef MASTER_CONTROLLER_AUTO_RESTART_EN
        bus_a.start = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`else
        bus_a.start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus_a.control !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL done_release: control %0d expected 0", bus_a.control);
        end
        bus_a.start = 1'b1;
        for (int t = 0; t <= LAST; t++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            model_at(MX, NL, t, ctl, lay, mc);
            n_tests++;
            if (bus_a.control !== 3'(ctl) || bus_a.layer_idx !== 2'(lay)) begin
                n_fail++;
                $display("[TB] FAIL rerun t=%0d: got ctl %0d lay %0d expected ctl %0d lay %0d",
                         t, bus_a.control, bus_a.layer_idx, ctl, lay);
            end
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_small();
        int exp_seq[4] = '{1, 2, 3, 5};
        int busy_cnt;
        busy_cnt = 0;
        bus_b.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            if (bus_b.busy === 1'b1) busy_cnt++;
            n_tests++;
            if (bus_b.control !== 3'(exp_seq[i]) || bus_b.done !== (i == 3)) begin
                n_fail++;
                $display("[TB] FAIL small i=%0d: got ctl %0d done %0d expected ctl %0d",
                         i, bus_b.control, bus_b.done, exp_seq[i]);
            end
        end
        @(negedge clk);
        if (bus_b.busy === 1'b1) busy_cnt++;
        n_tests++;
        if (busy_cnt != 3 || bus_b.control !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL small_busy: got busy cycles %0d ctl %0d expected 3 and 0",
                     busy_cnt, bus_b.control);
        end
    endtask

    task automatic test_abort();
        int ctl, lay, mc, target;
        target = 2 * (MX + 3) + 1 + $urandom_range(0, MX - 1);
        bus_a.start = 1'b1;
        for (int t = 0; t <= target; t++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
            model_at(MX, NL, t, ctl, lay, mc);
            n_tests++;
            if (bus_a.control !== 3'(ctl) || bus_a.layer_idx !== 2'(lay) || bus_a.mac_cnt !== 3'(mc)) begin
                n_fail++;
                $display("[TB] FAIL abort_run t=%0d: got ctl %0d lay %0d mac %0d expected %0d %0d %0d",
                         t, bus_a.control, bus_a.layer_idx, bus_a.mac_cnt, ctl, lay, mc);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (bus_a.control !== 3'd0 || bus_a.layer_idx !== 2'd0 || bus_a.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_reset: got ctl %0d lay %0d busy %0d expected 0 0 0",
                     bus_a.control, bus_a.layer_idx, bus_a.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus_a.control !== 3'd0) begin
                n_fail++;
                $display("[TB] FAIL abort_idle i=%0d: control %0d expected 0", i, bus_a.control);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_full_run();
        test_done_hold();
        test_small();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/master_controller.md
# master_controller

Top-level sequencer for the FPGA neural network. It waits for `start`, then steps through `layer_no` layers. For each layer it issues a load phase, a multiply-accumulate phase of `max` cycles, an activation/write-back phase and a layer-advance phase. It broadcasts the current phase on a 3-bit `control` bus to the neuron/datapath blocks, so it sits above the layer datapath as the single source of phase sequencing.

## Interface
- `max`, default 5: MAC cycles per layer (max inputs per neuron); legal range ≥1.
- `layer_no`, default 4: number of layers to process; legal range ≥1.
- `clk` input, 1 bit: rising-edge clock.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: run request, level-sensitive, sampled on rising `clk`.
- `control` output, 3 bits: phase code (encoding below).
- `layer_idx` output, LW bits: current layer, 0..`layer_no`-1. LW = max(1, clog2(`layer_no`)).
- `mac_cnt` output, CW bits: MAC cycle index within a layer, 0..`max`-1. CW = max(1, clog2(`max`)).
- `busy` output, 1 bit: high in every state except IDLE and DONE.
- `done` output, 1 bit: high in DONE.

Reset values of all outputs: `control`=0, `layer_idx`=0, `mac_cnt`=0, `busy`=0, `done`=0.

## Operation
- Moore FSM. All outputs are decoded from registered state and counters only; no combinational path from `start` to any output.
- Control codes: IDLE=0, LOAD=1, MAC=2, ACT=3, NEXT=4, DONE=5. Codes 6 and 7 are never driven.
- IDLE: if `start`=1, go to LOAD with `layer_idx`=0 and `mac_cnt`=0.
- LOAD: lasts 1 cycle, then MAC with `mac_cnt`=0.
- MAC: `mac_cnt` increments each cycle. When `mac_cnt`=`max`-1, go to ACT. For `max`=1, MAC lasts exactly 1 cycle.
- ACT: lasts 1 cycle.
  - If `layer_idx`=`layer_no`-1, go to DONE.
  - Otherwise go to NEXT.
- NEXT: lasts 1 cycle; `layer_idx` increments; go to LOAD.
- DONE: `done`=1, `layer_idx` holds the last layer.
  - If `start`=0, go to IDLE.
  - If `start`=1, behaviour is set by Configuration.
- `start` is ignored in LOAD, MAC, ACT and NEXT. Deasserting it mid-run does not abort the run.
- `rst` asserted in any state: immediate return to IDLE with reset output values; the run is abandoned.
- `mac_cnt` is 0 in every state other than MAC.

## Timing
- `start` sampled high at edge E0 in IDLE → `control`=1 during the cycle following E0.
- Per non-final layer: 1 (LOAD) + `max` (MAC) + 1 (ACT) + 1 (NEXT) cycles. Final layer: `max`+2 cycles.
- Total from E0 to DONE: `layer_no`·(`max`+3) − 1 cycles. With defaults (5, 4), DONE is entered at edge E0+31.
- Reset deassertion: the first `start` sample is at the first rising edge after `rst` falls.

## Configuration
- `MASTER_CONTROLLER_AUTO_RESTART_EN` defined: from DONE with `start`=1, go directly to LOAD with `layer_idx`=0. Inference repeats back-to-back, with 1 DONE cycle between runs.
- Not defined: DONE holds while `start`=1. A new run requires `start` to return to 0 (DONE→IDLE), then be reasserted.

## Test plan
- Reset: assert `rst` mid-clock → `control`=0, `busy`=0, `done`=0 immediately, without waiting for an edge.
- Default params, `start` raised at 20 ns with a 10 ns clock → `control` sequence 1, 2×5, 3, 4 repeated 3 times, then 1, 2×5, 3, then 5. `layer_idx` steps 0→3; DONE reached 31 cycles after the start edge.
- Macro undefined, `start` held high → `control` stays 5. Drop `start` → `control`=0 next cycle. Reassert → new run starts from layer 0.
- Macro defined, `start` held high → after 1 cycle of code 5, code 1 follows with `layer_idx`=0.
- `max`=1, `layer_no`=1 → sequence 1, 2, 3, 5; `busy` high for exactly 3 cycles.
- `start` pulsed for 1 cycle, then `rst` asserted during the MAC of layer 2 → return to IDLE, `control`=0. No restart while `start`=0.
